// File: rtl/bicubic_rsp_packer_if.sv
// Stream bundle around the response packer: 4-pixel group input from the
// bicubic core, packed-word output toward access control / write-back.
interface bicubic_rsp_packer_if #(
  parameter int CHANNEL_WIDTH = 8
);
  logic                       bcci_rsp_valid;
  logic                       bf_rsp_ready;
  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data1;
  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data2;
  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data3;
  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data4;
  logic                       ac_out_valid;
  logic                       ac_out_ready;
  logic [4*CHANNEL_WIDTH-1:0] ac_out_data;
  logic                       ac_out_sof;
  logic                       ac_out_eol;
  logic                       ac_out_eof;
  logic                       frame_done;

  // packer side
  modport slave (
    input  bcci_rsp_valid, bcci_rsp_data1, bcci_rsp_data2, bcci_rsp_data3,
           bcci_rsp_data4, ac_out_ready,
    output bf_rsp_ready, ac_out_valid, ac_out_data, ac_out_sof, ac_out_eol,
           ac_out_eof, frame_done
  );

  // upstream producer and downstream consumer side
  modport master (
    output bcci_rsp_valid, bcci_rsp_data1, bcci_rsp_data2, bcci_rsp_data3,
           bcci_rsp_data4, ac_out_ready,
    input  bf_rsp_ready, ac_out_valid, ac_out_data, ac_out_sof, ac_out_eol,
           ac_out_eof, frame_done
  );
endinterface

// File: rtl/bicubic_rsp_packer.sv
// Packs four adjacent upsampled pixels into one word, tags it with
// frame/row position and buffers it in a small register FIFO.
module bicubic_rsp_packer #(
  parameter int CHANNEL_WIDTH  = 8,
  parameter int BLOCK_SIZE     = 960,
  parameter int SRC_IMG_HEIGHT = 540,
  parameter int FIFO_DEPTH     = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  bicubic_rsp_packer_if.slave  bus
);

  localparam int DATA_W   = 4 * CHANNEL_WIDTH;
  localparam int ENTRY_W  = DATA_W + 3;
  localparam int OUT_ROWS = SRC_IMG_HEIGHT * 4;
  localparam int COL_W    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int ROW_W    = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BLOCK_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];

  logic               in_hs;
  logic               out_hs;
  logic               col_last;
  logic               row_last;
  logic               tag_sof;
  logic               tag_eol;
  logic               tag_eof;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;

  // Ready looks only at the registered count, so a full FIFO never
  // accepts even when a pop happens in the same cycle.
  assign bus.bf_rsp_ready = (count != CNT_FULL);
  assign bus.ac_out_valid = (count != '0);

  assign in_hs  = bus.bcci_rsp_valid & bus.bf_rsp_ready;
  assign out_hs = bus.ac_out_valid & bus.ac_out_ready;

  // Tags use the counters before this group advances them.
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign tag_sof  = (row == '0) && (col == '0);
  assign tag_eol  = col_last;
  assign tag_eof  = col_last && row_last;

  assign wr_entry = {tag_eof, tag_eol, tag_sof,
                     bus.bcci_rsp_data4, bus.bcci_rsp_data3,
                     bus.bcci_rsp_data2, bus.bcci_rsp_data1};

  // Empty FIFO presents zeros rather than a stale entry.
  assign head = bus.ac_out_valid ? mem[rd_ptr] : '0;
  assign {bus.ac_out_eof, bus.ac_out_eol, bus.ac_out_sof, bus.ac_out_data} = head;

  // Column/row position of the next group within the output frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_hs) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // FIFO storage: write the tagged word at the write pointer on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (in_hs) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (in_hs)  wr_ptr <= wr_ptr + 1'b1;
      if (out_hs) rd_ptr <= rd_ptr + 1'b1;
      case ({in_hs, out_hs})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // One-cycle pulse after the end-of-frame word leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= out_hs & head[ENTRY_W-1];
    end
  end

endmodule

// File: tb/tb_bicubic_rsp_packer.sv
// Directed bench for the response packer, 4x4-group frames, depth-4 FIFO.
module tb_bicubic_rsp_packer;

  localparam int CW    = 8;
  localparam int BS    = 4;
  localparam int SH    = 1;
  localparam int FD    = 4;
  localparam int FRAME = BS * SH * 4;

  typedef struct {
    logic [31:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
  } exp_t;

  logic clk;
  logic rst_n;

  bicubic_rsp_packer_if #(.CHANNEL_WIDTH(CW)) bus ();

  bicubic_rsp_packer #(
    .CHANNEL_WIDTH (CW),
    .BLOCK_SIZE    (BS),
    .SRC_IMG_HEIGHT(SH),
    .FIFO_DEPTH    (FD)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   g       = 0;
  int   fd_seen = 0;
  logic exp_fd  = 1'b0;
  exp_t q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] px(input int k, input int i);
    return 8'(8'h11 * (i + 1) + k);
  endfunction

  function automatic exp_t model(input int k);
    exp_t e;
    int   f;
    f      = k % FRAME;
    e.data = {px(k, 3), px(k, 2), px(k, 1), px(k, 0)};
    e.sof  = (f == 0);
    e.eol  = ((k % BS) == BS - 1);
    e.eof  = (f == FRAME - 1);
    return e;
  endfunction

  // One cycle: check outputs at the falling edge, then drive the next inputs.
  task automatic step(input bit v, input bit r);
    exp_t e;
    @(negedge clk);
    check("frame_done", bus.frame_done, exp_fd);
    if (bus.frame_done) fd_seen++;
    check("out_valid", bus.ac_out_valid, q.size() != 0);
    check("in_ready", bus.bf_rsp_ready, q.size() != FD);
    exp_fd = 1'b0;
    bus.ac_out_ready = r;
    if (bus.ac_out_valid && q.size() != 0) begin
      e = q[0];
      check("data", bus.ac_out_data, e.data);
      check("sof", bus.ac_out_sof, e.sof);
      check("eol", bus.ac_out_eol, e.eol);
      check("eof", bus.ac_out_eof, e.eof);
      if (r) begin
        exp_fd = e.eof;
        void'(q.pop_front());
      end
    end
    bus.bcci_rsp_valid = v;
    bus.bcci_rsp_data1 = px(g, 0);
    bus.bcci_rsp_data2 = px(g, 1);
    bus.bcci_rsp_data3 = px(g, 2);
    bus.bcci_rsp_data4 = px(g, 3);
    if (v && bus.bf_rsp_ready) begin
      q.push_back(model(g));
      g++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q.size() != 0 || exp_fd); i++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("drain_empty", q.size(), 0);
  endtask

  task automatic run_stream(input int n);
    int start;
    start = g;
    for (int i = 0; i < n * 4 + 20 && (g - start) < n; i++) step(1'b1, 1'b1);
    check("stream_pushed", g - start, n);
    drain();
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.bcci_rsp_valid = 1'b0;
    bus.ac_out_ready   = 1'b0;
    bus.bcci_rsp_data1 = '0;
    bus.bcci_rsp_data2 = '0;
    bus.bcci_rsp_data3 = '0;
    bus.bcci_rsp_data4 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    g       = 0;
    exp_fd  = 1'b0;
    fd_seen = 0;
  endtask

  initial begin
    // 1: reset and idle
    do_reset();
    repeat (2) step(1'b0, 1'b1);
    check("rst_valid", bus.ac_out_valid, 0);
    check("rst_ready", bus.bf_rsp_ready, 1);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_data", bus.ac_out_data, 0);

    // 2: single group
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("t2_data", bus.ac_out_data, 32'h4433_2211);
    check("t2_sof", bus.ac_out_sof, 1);
    check("t2_eol", bus.ac_out_eol, 0);
    check("t2_eof", bus.ac_out_eof, 0);
    step(1'b0, 1'b1);
    check("t2_empty", bus.ac_out_valid, 0);

    // 3: one full frame, constant valid and ready
    do_reset();
    run_stream(16);
    check("t3_frame_done_cnt", fd_seen, 1);

    // 4: backpressure with a full FIFO
    do_reset();
    repeat (4) step(1'b1, 1'b0);
    check("t4_pushed4", g, 4);
    step(1'b1, 1'b0);
    check("t4_ready_low", bus.bf_rsp_ready, 0);
    check("t4_stalled", g, 4);
    repeat (2) step(1'b1, 1'b0);
    check("t4_head", bus.ac_out_data, 32'h4433_2211);
    step(1'b1, 1'b1);
    check("t4_no_passthru", g, 4);
    for (int i = 0; i < 10 && g < 5; i++) step(1'b1, 1'b1);
    check("t4_pushed5", g, 5);
    drain();

    // 5: back-to-back frames
    do_reset();
    run_stream(32);
    check("t5_frame_done_cnt", fd_seen, 2);

    // 6: reset mid-frame with two words queued
    do_reset();
    repeat (5) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("t6_queued", q.size(), 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", bus.ac_out_valid, 0);
    check("t6_async_ready", bus.bf_rsp_ready, 1);
    check("t6_async_data", bus.ac_out_data, 0);
    check("t6_async_sof", bus.ac_out_sof, 0);
    check("t6_async_fd", bus.frame_done, 0);
    do_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("t6_sof", bus.ac_out_sof, 1);
    check("t6_data", bus.ac_out_data, 32'h4433_2211);
    run_stream(15);
    check("t6_frame_done_cnt", fd_seen, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
